// File: rtl/lif_run_sequencer.sv
// lif_run_sequencer: host-side driver for the LIF neuron core.
// Accepts a "run N timesteps" command. For each timestep it fetches one
// input-current sample and pulses the neuron start. It then waits for the
// neuron's valid pulse and records the spike result. A watchdog ends the run
// with an error flag if the neuron never answers.
module lif_run_sequencer #(
  parameter int DATA_W    = 16,
  parameter int STEP_W    = 8,
  parameter int TRAIN_W   = 32,
  parameter int START_CYC = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [STEP_W-1:0]  cmd_steps,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               nrn_start,
  output logic [DATA_W-1:0]  nrn_i_data,
  input  logic               nrn_valid,
  input  logic               nrn_spike,
  output logic [TRAIN_W-1:0] spike_train,
  output logic [STEP_W-1:0]  spike_count,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  localparam int SC_W = (START_CYC > 1) ? $clog2(START_CYC) : 1;
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SC_W-1:0]   START_LAST = SC_W'(START_CYC - 1);
  localparam logic [WD_W-1:0]   WD_LAST    = WD_W'(TIMEOUT - 1);
  localparam logic [STEP_W-1:0] CNT_MAX    = {STEP_W{1'b1}};
  localparam logic [STEP_W-1:0] STEP_ONE   = {{(STEP_W-1){1'b0}}, 1'b1};
  localparam logic [STEP_W-1:0] STEP_ZERO  = {STEP_W{1'b0}};

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [STEP_W-1:0] remaining;
  logic [SC_W-1:0]   start_cnt;
  logic [WD_W-1:0]   wd_cnt;

  // Handshake/event strobes decoded alongside the next state.
  logic cmd_fire;
  logic in_fire;
  logic valid_fire;
  logic wd_expire;
  logic enter_wait;

  // Ready signals are a plain decode of the current state.
  assign cmd_ready = (state == S_IDLE);
  assign in_ready  = (state == S_FETCH);

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and per-cycle event strobes.
  always_comb begin
    state_nxt  = state;
    cmd_fire   = 1'b0;
    in_fire    = 1'b0;
    valid_fire = 1'b0;
    wd_expire  = 1'b0;
    enter_wait = 1'b0;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          cmd_fire  = 1'b1;
          state_nxt = (cmd_steps == STEP_ZERO) ? S_DONE : S_FETCH;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_FETCH: begin
        if (in_valid) begin
          in_fire   = 1'b1;
          state_nxt = S_START;
        end else begin
          state_nxt = S_FETCH;
        end
      end
      S_START: begin
        if (start_cnt == START_LAST) begin
          enter_wait = 1'b1;
          state_nxt  = S_WAIT;
        end else begin
          state_nxt = S_START;
        end
      end
      S_WAIT: begin
        // A valid arriving on the expiry cycle still counts as a normal step.
        if (nrn_valid) begin
          valid_fire = 1'b1;
          state_nxt  = (remaining == STEP_ONE) ? S_DONE : S_FETCH;
        end else if (wd_cnt == WD_LAST) begin
          wd_expire = 1'b1;
          state_nxt = S_DONE;
        end else begin
          state_nxt = S_WAIT;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Step bookkeeping: remaining steps, start-pulse length, watchdog.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remaining <= STEP_ZERO;
      start_cnt <= {SC_W{1'b0}};
      wd_cnt    <= {WD_W{1'b0}};
    end else begin
      if (cmd_fire) begin
        remaining <= cmd_steps;
      end else if (valid_fire) begin
        remaining <= remaining - STEP_ONE;
      end else begin
        remaining <= remaining;
      end

      if (in_fire) begin
        start_cnt <= {SC_W{1'b0}};
      end else if (state == S_START) begin
        start_cnt <= start_cnt + {{(SC_W-1){1'b0}}, 1'b1};
      end else begin
        start_cnt <= start_cnt;
      end

      if (enter_wait) begin
        wd_cnt <= {WD_W{1'b0}};
      end else if (state == S_WAIT) begin
        wd_cnt <= wd_cnt + {{(WD_W-1){1'b0}}, 1'b1};
      end else begin
        wd_cnt <= wd_cnt;
      end
    end
  end

  // Registered control outputs, derived from the state being entered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nrn_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      nrn_start <= (state_nxt == S_START);
      busy      <= (state_nxt == S_FETCH) || (state_nxt == S_START) ||
                   (state_nxt == S_WAIT);
      done      <= (state_nxt == S_DONE);
    end
  end

  // Sample hold, spike history, spike count and sticky timeout flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      nrn_i_data  <= {DATA_W{1'b0}};
      spike_train <= {TRAIN_W{1'b0}};
      spike_count <= STEP_ZERO;
      timeout_err <= 1'b0;
    end else begin
      if (in_fire) begin
        nrn_i_data <= in_data;
      end else begin
        nrn_i_data <= nrn_i_data;
      end

      if (cmd_fire) begin
        spike_train <= {TRAIN_W{1'b0}};
        spike_count <= STEP_ZERO;
      end else if (valid_fire) begin
        spike_train <= {spike_train[TRAIN_W-2:0], nrn_spike};
        if (nrn_spike && (spike_count != CNT_MAX)) begin
          spike_count <= spike_count + STEP_ONE;
        end else begin
          spike_count <= spike_count;
        end
      end else begin
        spike_train <= spike_train;
        spike_count <= spike_count;
      end

      if (cmd_fire) begin
        timeout_err <= 1'b0;
      end else if (wd_expire) begin
        timeout_err <= 1'b1;
      end else begin
        timeout_err <= timeout_err;
      end
    end
  end

endmodule

// File: tb/tb_lif_run_sequencer.sv
// Testbench for lif_run_sequencer: directed and randomized runs against a
// run-level reference model (expected spike history, count and error flag
// computed from the per-step spike/latency tables).
module tb_lif_run_sequencer;

  localparam int DATA_W    = 16;
  localparam int STEP_W    = 8;
  localparam int TRAIN_W   = 32;
  localparam int START_CYC = 2;
  localparam int TIMEOUT   = 64;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [STEP_W-1:0]  cmd_steps = '0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [DATA_W-1:0]  in_data = '0;
  logic               nrn_start;
  logic [DATA_W-1:0]  nrn_i_data;
  logic               nrn_valid = 1'b0;
  logic               nrn_spike = 1'b0;
  logic [TRAIN_W-1:0] spike_train;
  logic [STEP_W-1:0]  spike_count;
  logic               busy;
  logic               done;
  logic               timeout_err;

  lif_run_sequencer #(
    .DATA_W(DATA_W), .STEP_W(STEP_W), .TRAIN_W(TRAIN_W),
    .START_CYC(START_CYC), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_steps(cmd_steps),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .nrn_start(nrn_start), .nrn_i_data(nrn_i_data),
    .nrn_valid(nrn_valid), .nrn_spike(nrn_spike),
    .spike_train(spike_train), .spike_count(spike_count),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Per-step stimulus tables: sample, spike, neuron latency (-1 = never), stall.
  logic [DATA_W-1:0] samp  [256];
  bit                spk   [256];
  int                lat   [256];
  int                stall [256];
  logic [DATA_W-1:0] last_samp = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Run-level model: history is a left-shifting bit record of answered steps.
  task automatic model(input int steps, output logic [31:0] tr, output int cnt, output bit to);
    tr = 32'd0;
    cnt = 0;
    to = 1'b0;
    for (int s = 0; s < steps; s++) begin
      if (lat[s] < 0) begin
        to = 1'b1;
        break;
      end
      tr = (tr << 1) | (spk[s] ? 32'd1 : 32'd0);
      if (spk[s] && cnt < 255) cnt++;
    end
  endtask

  task automatic run_cmd(input int steps);
    logic [31:0] etr;
    int          ecnt;
    bit          eto;
    int          hi;
    bit          aborted;
    logic [7:0]  st8;
    model(steps, etr, ecnt, eto);
    st8 = steps[7:0];
    check_eq("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_steps = st8;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_steps = 8'($urandom);
    aborted = 1'b0;
    for (int s = 0; s < steps && !aborted; s++) begin
      check_eq("busy_fetch", busy, 1);
      check_eq("in_ready_fetch", in_ready, 1);
      check_eq("start_low_fetch", nrn_start, 0);
      for (int k = 0; k < stall[s]; k++) begin
        nrn_valid = ($urandom_range(0, 1) == 1);
        nrn_spike = 1'b1;
        @(negedge clk);
        check_eq("stall_in_ready", in_ready, 1);
        check_eq("stall_no_start", nrn_start, 0);
      end
      nrn_valid = 1'b0;
      nrn_spike = 1'b0;
      in_valid = 1'b1;
      in_data = samp[s];
      @(negedge clk);
      in_valid = 1'b0;
      in_data = 16'($urandom);
      last_samp = samp[s];
      hi = 0;
      while (nrn_start === 1'b1 && hi < START_CYC + 4) begin
        check_eq("i_data", nrn_i_data, samp[s]);
        check_eq("in_ready_start", in_ready, 0);
        hi++;
        @(negedge clk);
      end
      check_eq("start_len", hi, START_CYC);
      if (lat[s] >= 0) begin
        for (int k = 0; k < lat[s]; k++) @(negedge clk);
        check_eq("in_ready_wait", in_ready, 0);
        nrn_valid = 1'b1;
        nrn_spike = spk[s];
        @(negedge clk);
        nrn_valid = 1'b0;
        nrn_spike = 1'b0;
      end else begin
        repeat (TIMEOUT - 1) @(negedge clk);
        check_eq("no_early_timeout", done, 0);
        check_eq("busy_wait", busy, 1);
        @(negedge clk);
        aborted = 1'b1;
      end
    end
    check_eq("done_pulse", done, 1);
    check_eq("busy_done", busy, 0);
    check_eq("start_done", nrn_start, 0);
    check_eq("spike_train", spike_train, etr);
    check_eq("spike_count", spike_count, ecnt);
    check_eq("timeout_err", timeout_err, eto);
    check_eq("i_data_hold", nrn_i_data, last_samp);
    @(negedge clk);
    check_eq("done_one_cycle", done, 0);
    check_eq("cmd_ready_after", cmd_ready, 1);
    check_eq("train_hold", spike_train, etr);
    check_eq("count_hold", spike_count, ecnt);
  endtask

  task automatic check_reset_outputs();
    check_eq("rst_start", nrn_start, 0);
    check_eq("rst_i_data", nrn_i_data, 0);
    check_eq("rst_train", spike_train, 0);
    check_eq("rst_count", spike_count, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_timeout", timeout_err, 0);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_cmd_ready", cmd_ready, 1);
  endtask

  task automatic clear_tables();
    for (int i = 0; i < 256; i++) begin
      samp[i] = 16'(i * 37 + 5);
      spk[i] = 1'b0;
      lat[i] = 3;
      stall[i] = 0;
    end
  endtask

  initial begin
    logic [31:0] tr_before;
    logic [7:0]  cnt_before;
    int          r;
    clear_tables();
    repeat (2) @(negedge clk);
    check_reset_outputs();
    rst = 1'b1;
    @(negedge clk);

    // Single step with spike, neuron answers 9 cycles after start falls.
    samp[0] = 16'h0100; spk[0] = 1'b1; lat[0] = 9;
    run_cmd(1);

    // Five steps, spike pattern 1,0,1,1,0.
    clear_tables();
    spk[0] = 1'b1; spk[1] = 1'b0; spk[2] = 1'b1; spk[3] = 1'b1; spk[4] = 1'b0;
    run_cmd(5);
    check_eq("pattern_train_const", spike_train, 32'h0000_0016);

    // Input stall of 10 cycles before the second sample.
    clear_tables();
    spk[0] = 1'b1; spk[1] = 1'b1; stall[1] = 10;
    run_cmd(2);

    // Timeout on step 2, then a normal run clears the error.
    clear_tables();
    spk[0] = 1'b1; lat[1] = -1;
    run_cmd(3);
    clear_tables();
    spk[0] = 1'b1;
    run_cmd(1);

    // Valid on the watchdog's last cycle wins over the timeout.
    clear_tables();
    spk[0] = 1'b1; lat[0] = TIMEOUT - 1;
    run_cmd(1);

    // Zero-length run, then a spurious valid in IDLE.
    run_cmd(0);
    tr_before = spike_train;
    cnt_before = spike_count;
    nrn_valid = 1'b1;
    nrn_spike = 1'b1;
    @(negedge clk);
    nrn_valid = 1'b0;
    nrn_spike = 1'b0;
    @(negedge clk);
    check_eq("idle_valid_train", spike_train, tr_before);
    check_eq("idle_valid_count", spike_count, cnt_before);
    check_eq("idle_valid_busy", busy, 0);
    check_eq("idle_valid_ready", cmd_ready, 1);

    // Reset while nrn_start is high.
    clear_tables();
    spk[0] = 1'b1; lat[0] = 4;
    run_cmd(1);
    cmd_valid = 1'b1;
    cmd_steps = 8'd3;
    @(negedge clk);
    cmd_valid = 1'b0;
    in_valid = 1'b1;
    in_data = 16'h1234;
    @(negedge clk);
    in_valid = 1'b0;
    check_eq("pre_reset_start", nrn_start, 1);
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    rst = 1'b1;
    last_samp = '0;
    clear_tables();
    spk[0] = 1'b1;
    run_cmd(1);

    // Randomized runs.
    for (int n = 0; n < 20; n++) begin
      int steps;
      steps = $urandom_range(0, 8);
      for (int s = 0; s < steps; s++) begin
        samp[s] = 16'($urandom);
        spk[s] = ($urandom_range(0, 1) == 1);
        stall[s] = $urandom_range(0, 3);
        r = $urandom_range(0, 19);
        if (r == 0) lat[s] = -1;
        else if (r == 1) lat[s] = TIMEOUT - 1;
        else lat[s] = $urandom_range(0, 12);
      end
      run_cmd(steps);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
